// File: rtl/eth_vlg_pkg.sv
// Shared Ethernet types: byte stream, local device address and parsed MAC header.
// Multi-byte fields are byte arrays with index [N-1] holding the first byte on the wire.
package eth_vlg_pkg;

  typedef logic [5:0][7:0] mac_addr_t;
  typedef logic [1:0][7:0] ethertype_t;

  typedef struct packed {
    mac_addr_t  dst;
    mac_addr_t  src;
    ethertype_t ethertype;
  } mac_hdr_t;

  typedef struct packed {
    mac_addr_t mac_addr;
  } dev_t;

  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } stream_t;

  localparam mac_addr_t MAC_BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam int        HDR_LEN_ETH = 14;

  typedef enum logic [1:0] {IDLE, HDR, PLD, DROP} rx_fsm_t;

  // Wire byte idx lands at the matching slot of the packed header (byte 0 = dst MSB).
  function automatic mac_hdr_t hdr_put(mac_hdr_t h, logic [3:0] idx, logic [7:0] b);
    mac_hdr_t r;
    r = h;
    r[8*(HDR_LEN_ETH-1-int'(idx)) +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/mac_rx_hdr_parse_if.sv
// Byte-stream bundle; master drives the stream, slave receives it.
interface mac_rx_hdr_parse_if import eth_vlg_pkg::*; ();
  stream_t st;
  modport master (output st);
  modport slave  (input  st);
endinterface

// File: rtl/mac_rx_hdr_parse.sv
// Ethernet RX header parser: captures dst/src/ethertype, filters on dst, strips
// the header and forwards the payload one cycle late.
module mac_rx_hdr_parse import eth_vlg_pkg::*; #(
  parameter bit PROMISC = 1'b0,
  parameter int HDR_LEN = HDR_LEN_ETH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  dev_t                      dev,
  mac_rx_hdr_parse_if.slave         rx,
  mac_rx_hdr_parse_if.master        pld,
  output mac_hdr_t                  hdr,
  output logic                      hdr_val,
  output logic                      runt,
  output logic                      drop
);

  localparam logic [3:0] LEN4  = 4'(HDR_LEN);
  localparam logic [3:0] LAST4 = 4'(HDR_LEN-1);

  rx_fsm_t    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  mac_hdr_t   sh_q, sh_d;
  mac_addr_t  mac_q;
  logic       first_q, first_d;

  stream_t    in;
  stream_t    pld_d;
  logic       hdr_val_d, runt_d, drop_d;
  logic       start, hb, last, pass;
  logic [3:0] idx;

  assign in    = rx.st;
  assign start = in.val & in.sof;
  assign hb    = in.val & (start | (state_q == HDR));
  assign idx   = start ? 4'd0 : cnt_q;
  assign last  = hb & (idx == LAST4);
  assign pass  = PROMISC | (sh_q.dst == mac_q) | (sh_q.dst == MAC_BCAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      mac_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      first_q <= first_d;
      if (start) mac_q <= dev.mac_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    first_d = first_q;
    if (state_q == IDLE && !start) cnt_d = '0;
    if (hb) begin
      sh_d  = hdr_put(sh_q, idx, in.dat);
      cnt_d = start ? 4'd1 : ((cnt_q >= LEN4) ? LEN4 : cnt_q + 4'd1);
      if (in.eof)                state_d = IDLE;
      else if (in.err)           state_d = DROP;
      else if (last)             state_d = pass ? PLD : DROP;
      else                       state_d = HDR;
      first_d = !in.eof && !in.err && last && pass;
    end else if (in.val) begin
      if (state_q == PLD) first_d = 1'b0;
      if ((state_q == PLD || state_q == DROP) && in.eof) state_d = IDLE;
    end
  end

  // A header that completes with eof, err or a filter miss never reaches PLD.
  always_comb begin
    pld_d     = '0;
    hdr_val_d = 1'b0;
    runt_d    = 1'b0;
    drop_d    = 1'b0;
    if (hb) begin
      if (in.eof) begin
        runt_d = !last | (pass & !in.err);
        drop_d = last & !(pass & !in.err);
      end else begin
        drop_d = last & !in.err & !pass;
      end
    end
    if (state_q == PLD && in.val) begin
      if (start) begin
        if (!first_q) begin
          pld_d.val = 1'b1;
          pld_d.eof = 1'b1;
          pld_d.err = 1'b1;
        end
      end else begin
        pld_d.dat = in.dat;
        pld_d.val = 1'b1;
        pld_d.sof = first_q;
        pld_d.eof = in.eof;
        pld_d.err = in.err;
        hdr_val_d = first_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pld.st  <= '0;
      hdr     <= '0;
      hdr_val <= 1'b0;
      runt    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      pld.st  <= pld_d;
      hdr_val <= hdr_val_d;
      runt    <= runt_d;
      drop    <= drop_d;
      if (hdr_val_d) hdr <= sh_q;
    end
  end

endmodule

// File: tb/tb_mac_rx_hdr_parse.sv
// Bench for mac_rx_hdr_parse: two instances (PROMISC 0/1) share one input
// stream; a frame-level model predicts payload, header and pulse counts.
module tb_mac_rx_hdr_parse;
  import eth_vlg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  dev_t dev;
  mac_hdr_t hdr0, hdr1;
  logic hv0, hv1, runt0, runt1, drop0, drop1;

  mac_rx_hdr_parse_if rx_if ();
  mac_rx_hdr_parse_if pld0_if ();
  mac_rx_hdr_parse_if pld1_if ();

  always #5 clk = ~clk;

  mac_rx_hdr_parse #(.PROMISC(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .dev(dev), .rx(rx_if), .pld(pld0_if),
    .hdr(hdr0), .hdr_val(hv0), .runt(runt0), .drop(drop0));

  mac_rx_hdr_parse #(.PROMISC(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .dev(dev), .rx(rx_if), .pld(pld1_if),
    .hdr(hdr1), .hdr_val(hv1), .runt(runt1), .drop(drop1));

  int errors = 0;
  int checks = 0;

  stream_t  eq0[$], eq1[$];
  mac_hdr_t eh0[$], eh1[$];
  int got_pld[2], got_hv[2], got_runt[2], got_drop[2];
  int exp_hv[2], exp_runt[2], exp_drop[2];
  mac_hdr_t got_hdr[2];
  logic [7:0] fb[$];

  task automatic ck(input string name, input int p, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", name, p, got, exp);
    end
  endtask

  task automatic chk(input int p, input stream_t o, input logic hv, input mac_hdr_t h,
                     input logic r, input logic d);
    stream_t e;
    mac_hdr_t eh;
    if (o.val) begin
      got_pld[p]++;
      if ((p == 0 ? eq0.size() : eq1.size()) == 0) begin
        ck("pld_unexpected", p, 128'(o), 128'(0));
      end else begin
        e = (p == 0) ? eq0.pop_front() : eq1.pop_front();
        ck("pld_byte", p, 128'(o), 128'(e));
      end
    end
    if (hv) begin
      got_hv[p]++;
      got_hdr[p] = h;
      ck("hv_with_sof", p, 128'({o.val, o.sof}), 128'(2'b11));
      if ((p == 0 ? eh0.size() : eh1.size()) == 0) begin
        ck("hdr_unexpected", p, 128'(h), 128'(0));
      end else begin
        eh = (p == 0) ? eh0.pop_front() : eh1.pop_front();
        ck("hdr", p, 128'(h), 128'(eh));
      end
    end
    if (r) got_runt[p]++;
    if (d) got_drop[p]++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk(0, pld0_if.st, hv0, hdr0, runt0, drop0);
      chk(1, pld1_if.st, hv1, hdr1, runt1, drop1);
    end
  end

  task automatic push_pld(input int p, input stream_t s);
    if (p == 0) eq0.push_back(s); else eq1.push_back(s);
  endtask

  // Frame-level rules: what a frame of n bytes in fb must produce.
  task automatic model(input int p, input int n, input bit eof_end, input int err_at);
    mac_hdr_t h;
    bit ok;
    stream_t s;
    h.dst       = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    h.src       = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
    h.ethertype = {fb[12], fb[13]};
    if (err_at >= 0 && err_at < 14 && err_at < n) begin
      if (eof_end && err_at == n-1) begin
        if (err_at < 13) exp_runt[p]++; else exp_drop[p]++;
      end
      return;
    end
    if (n < 14) begin
      if (eof_end) exp_runt[p]++;
      return;
    end
    ok = (p == 1) || (h.dst == dev.mac_addr) || (h.dst == MAC_BCAST);
    if (!ok) begin
      exp_drop[p]++;
      return;
    end
    if (n == 14) begin
      if (eof_end) exp_runt[p]++;
      return;
    end
    exp_hv[p]++;
    if (p == 0) eh0.push_back(h); else eh1.push_back(h);
    for (int i = 14; i < n; i++) begin
      s = '{dat: fb[i], val: 1'b1, sof: (i == 14), eof: (eof_end && i == n-1), err: 1'b0};
      push_pld(p, s);
    end
    if (!eof_end) push_pld(p, '{dat: 8'h00, val: 1'b1, sof: 1'b0, eof: 1'b1, err: 1'b1});
  endtask

  task automatic mk(input logic [47:0] dst, input logic [15:0] et, input int n, input int seed);
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(8'(8'h10 + i));
    fb.push_back(et[15:8]);
    fb.push_back(et[7:0]);
    for (int i = 14; i < n; i++) fb.push_back(8'(i*5 + seed));
  endtask

  task automatic send(input int lo, input int hi, input bit sof_first, input bit eof_end,
                      input bit gap, input int err_at);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      rx_if.st = '{dat: fb[i], val: 1'b1, sof: (sof_first && i == lo),
                   eof: (eof_end && i == hi), err: (i == err_at)};
      if (gap) begin
        @(negedge clk);
        rx_if.st = '0;
      end
    end
    @(negedge clk);
    rx_if.st = '0;
  endtask

  task automatic clr();
    for (int p = 0; p < 2; p++) begin
      got_pld[p] = 0; got_hv[p] = 0; got_runt[p] = 0; got_drop[p] = 0;
      exp_hv[p] = 0; exp_runt[p] = 0; exp_drop[p] = 0;
    end
  endtask

  task automatic fin(input string tname);
    repeat (4) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      ck({tname, "_hv"},   p, 128'(got_hv[p]),   128'(exp_hv[p]));
      ck({tname, "_runt"}, p, 128'(got_runt[p]), 128'(exp_runt[p]));
      ck({tname, "_drop"}, p, 128'(got_drop[p]), 128'(exp_drop[p]));
      ck({tname, "_left"}, p, 128'(p == 0 ? eq0.size() + eh0.size() : eq1.size() + eh1.size()), 128'(0));
    end
  endtask

  initial begin
    dev.mac_addr = 48'h02_00_00_00_00_01;
    rx_if.st = '0;
    clr();
    repeat (3) @(negedge clk);
    ck("rst_pld",  0, 128'(pld0_if.st), 128'(0));
    ck("rst_hdr",  0, 128'(hdr0), 128'(0));
    ck("rst_puls", 0, 128'({hv0, runt0, drop0}), 128'(0));
    rst = 1'b0;

    // Unicast 60-byte frame
    clr();
    mk(48'h02_00_00_00_00_01, 16'h0800, 60, 1);
    model(0, 60, 1, -1); model(1, 60, 1, -1);
    send(0, 59, 1, 1, 0, -1);
    fin("uni");
    ck("uni_npld", 0, 128'(got_pld[0]), 128'(46));
    ck("uni_et",   0, 128'(got_hdr[0].ethertype), 128'(16'h0800));

    // Filter miss: dropped by dut0, accepted by promiscuous dut1
    clr();
    mk(48'h02_00_00_00_00_02, 16'h0800, 60, 3);
    model(0, 60, 1, -1); model(1, 60, 1, -1);
    send(0, 59, 1, 1, 0, -1);
    fin("filt");
    ck("filt_drop", 0, 128'(got_drop[0]), 128'(1));
    ck("filt_npld", 0, 128'(got_pld[0]), 128'(0));
    ck("filt_prom", 1, 128'(got_pld[1]), 128'(46));

    // Broadcast ARP with val gaps
    clr();
    mk(48'hFF_FF_FF_FF_FF_FF, 16'h0806, 64, 7);
    model(0, 64, 1, -1); model(1, 64, 1, -1);
    send(0, 63, 1, 1, 1, -1);
    fin("bcast");
    ck("bcast_et", 0, 128'(got_hdr[0].ethertype), 128'(16'h0806));
    ck("bcast_n",  0, 128'(got_pld[0]), 128'(50));

    // Runt: eof on byte 9
    clr();
    mk(48'h02_00_00_00_00_01, 16'h0800, 10, 0);
    model(0, 10, 1, -1); model(1, 10, 1, -1);
    send(0, 9, 1, 1, 0, -1);
    fin("runt");
    ck("runt_cnt", 0, 128'(got_runt[0]), 128'(1));

    // Zero payload: accepted header ending on byte 13
    clr();
    mk(48'h02_00_00_00_00_01, 16'h0800, 14, 0);
    model(0, 14, 1, -1); model(1, 14, 1, -1);
    send(0, 13, 1, 1, 0, -1);
    fin("zero");
    ck("zero_hv",   0, 128'(got_hv[0]), 128'(0));
    ck("zero_runt", 0, 128'(got_runt[0]), 128'(1));

    // Header byte with err: silently discarded
    clr();
    mk(48'h02_00_00_00_00_01, 16'h0800, 40, 2);
    model(0, 40, 1, 3); model(1, 40, 1, 3);
    send(0, 39, 1, 1, 0, 3);
    fin("herr");

    // Abort at payload byte 20, then a clean frame
    clr();
    mk(48'h02_00_00_00_00_01, 16'h0800, 34, 4);
    model(0, 34, 0, -1); model(1, 34, 0, -1);
    send(0, 33, 1, 0, 0, -1);
    mk(48'h02_00_00_00_00_01, 16'h86DD, 60, 9);
    model(0, 60, 1, -1); model(1, 60, 1, -1);
    send(0, 59, 1, 1, 0, -1);
    fin("abort");
    ck("abort_n",  0, 128'(got_pld[0]), 128'(67));
    ck("abort_et", 0, 128'(got_hdr[0].ethertype), 128'(16'h86DD));

    // Reset at byte 7, rest of the frame without a new sof
    clr();
    mk(48'h02_00_00_00_00_01, 16'h0800, 60, 5);
    send(0, 6, 1, 0, 0, -1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ck("rst_mid_pld", 0, 128'(pld0_if.st), 128'(0));
    rst = 1'b0;
    send(7, 59, 0, 1, 0, -1);
    fin("rstmid");
    ck("rstmid_npld", 0, 128'(got_pld[0] + got_pld[1]), 128'(0));
    ck("rstmid_hdr",  0, 128'(hdr0), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout dut0 got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_rx_hdr_parse.md
MAC_RX_HDR_PARSE -- requirements
Module: mac_rx_hdr_parse

Interface
REQ-001 SHALL have parameter PROMISC, default 0; when 1, the destination-MAC filter is disabled.
REQ-002 SHALL have parameter HDR_LEN, default 14; it is the Ethernet header length in bytes and is fixed, not for override.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port dev, input, dev_t: local address; only dev.mac_addr is used, and it is sampled at the start of each frame.
REQ-006 SHALL have port rx, input, stream_t: the byte stream from the MAC receive path (dat/val/sof/eof/err).
REQ-007 SHALL have port pld, output, stream_t: the payload stream with the header stripped.
REQ-008 SHALL have port hdr, output, mac_hdr_t: dst, src and ethertype of the current accepted frame.
REQ-009 SHALL have port hdr_val, output, 1: one-cycle pulse when hdr is updated.
REQ-010 SHALL have port runt, output, 1: one-cycle pulse when a frame ends before its header is complete.
REQ-011 SHALL have port drop, output, 1: one-cycle pulse when a frame fails the destination filter.

Function
REQ-012 SHALL count bytes only on cycles with rx.val=1; val gaps are allowed anywhere.
REQ-013 SHALL implement the states IDLE, HDR, PLD and DROP.
REQ-014 In IDLE, rx.val & rx.sof SHALL store byte 0 and go to HDR, with byte counter = 1.
REQ-015 Byte order SHALL be network order: bytes 0-5 go to dst[5]..dst[0], bytes 6-11 to src[5]..src[0], and bytes 12-13 to ethertype[1], ethertype[0].
REQ-016 At byte 13, the filter SHALL pass if PROMISC=1, or dst==dev.mac_addr, or dst==MAC_BCAST.
- On pass: load hdr and go to PLD.
- On fail: pulse drop and go to DROP if byte 13 lacks eof, or go to IDLE if byte 13 has eof.
REQ-017 hdr_val SHALL pulse in the same cycle as the first pld byte.
REQ-018 hdr SHALL be held stable until the next accepted header.
REQ-019 In PLD, each valid rx byte SHALL appear on pld exactly 1 cycle later, with dat/eof/err copied.
- pld.sof SHALL be 1 on the first payload byte only.
- pld.val SHALL be 0 in all other cycles.
REQ-020 An accepted frame whose byte 13 carries eof (zero payload) SHALL produce no pld output and no hdr_val, and SHALL pulse runt.
REQ-021 rx.eof in HDR before byte 13 SHALL pulse runt one cycle later and return to IDLE.
REQ-022 A header byte with rx.err=1 SHALL cause the frame to be discarded via DROP, with no runt or drop pulse unless that byte also carries eof.
REQ-023 In DROP, bytes SHALL be discarded until rx.eof, then the state SHALL return to IDLE.
REQ-024 rx.sof arriving in HDR, PLD or DROP SHALL abort the current frame and restart at byte 0 in HDR.
- An aborted PLD frame SHALL get a single-cycle pld.val=1 with eof=1 and err=1 and dat=0x00.
REQ-025 The byte counter SHALL be 4 bits and saturate at HDR_LEN; it SHALL never wrap.
REQ-026 The payload length SHALL be unbounded; there is no counter in PLD.

Reset
REQ-027 On rst: state=IDLE, counter=0, pld all zero, hdr=0, hdr_val=0, runt=0, drop=0.
REQ-028 rst asserted mid-frame SHALL discard the frame silently; bytes after release are ignored until the next rx.sof.

Structure
REQ-029 mac_hdr_t {mac_addr_t dst; mac_addr_t src; ethertype_t ethertype;}, MAC_BCAST (48'hFFFFFFFFFFFF) and HDR_LEN_ETH (14) SHALL be added to the shared eth_vlg_pkg.
REQ-030 The block SHALL be a single module with no sub-module.
REQ-031 The ethertype dispatcher downstream SHALL consume hdr and pld.

Verification
REQ-032 Unicast: dev.mac_addr=02:00:00:00:00:01; send a 60-byte frame to that address with ethertype 0x0800 -> hdr_val once, hdr.ethertype=16'h0800, 46 pld bytes, sof on the first, eof on the last, and no drop or runt.
REQ-033 Filter: dst=02:00:00:00:00:02 with PROMISC=0 -> drop pulses once and there is no pld activity; the same frame with PROMISC=1 -> accepted.
REQ-034 Broadcast with val gaps: dst=FF:FF:FF:FF:FF:FF, ethertype 0x0806, val toggling every other cycle -> hdr_val once and pld bytes match the input order.
REQ-035 Runt: a 10-byte frame with eof on byte 9 -> runt pulses once, and no hdr_val, pld or drop.
REQ-036 Abort: sof arrives at payload byte 20 -> pld gets an eof+err byte, then the new frame parses normally.
REQ-037 Reset mid-frame: rst for 2 cycles at byte 7, followed by the remaining bytes with no new sof -> all outputs stay 0.
